// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use stall, branch flush and memory freeze.
// Optional perf counters: define ID_EX_PERF_CNT_EN.
module id_ex_hazard_reg #(
  parameter int XLEN  = 32,
  parameter int CTRLW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             id_RegWEn,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic [CTRLW-1:0] id_ctrl,
  input  logic             ex_branch_taken,
  input  logic             mem_stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic             ex_RegWEn,
  output logic             ex_MemRead,
  output logic             ex_MemWrite,
  output logic [CTRLW-1:0] ex_ctrl,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             lu_stall
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]      perf_lu_cnt,
  output logic [31:0]      perf_flush_cnt
`endif
);

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic             RegWEn;
    logic             MemRead;
    logic             MemWrite;
    logic [CTRLW-1:0] ctrl;
  } id_ex_t;

  typedef enum logic [0:0] {
    RUN = 1'b0,
    LU  = 1'b1
  } state_e;

  id_ex_t ex_q, ex_d;
  state_e state_q, state_d;
  logic   hz;
  logic   rs1_hit;
  logic   rs2_hit;

  // Load in EX whose destination the ID instruction really reads.
  always_comb begin
    rs1_hit = id_use_rs1 & (id_rs1 == ex_q.rd);
    rs2_hit = id_use_rs2 & (id_rs2 == ex_q.rd);
    hz = ex_q.valid & ex_q.MemRead & (ex_q.rd != 5'd0)
       & id_valid & (rs1_hit | rs2_hit);
  end

  // Prioritised per-cycle action: reset, freeze, flush, bubble, capture.
  always_comb begin
    ex_d        = ex_q;
    state_d     = state_q;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    lu_stall    = 1'b0;
    if (rst) begin
      ex_d    = '0;
      state_d = RUN;
    end else if (mem_stall) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
    end else if (ex_branch_taken) begin
      ex_d        = '0;
      state_d     = RUN;
      if_id_flush = 1'b1;
    end else if (hz) begin
      ex_d     = '0;
      state_d  = LU;
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      lu_stall = 1'b1;
    end else begin
      ex_d.valid    = id_valid;
      ex_d.pc       = id_pc;
      ex_d.rs1      = id_rs1;
      ex_d.rs2      = id_rs2;
      ex_d.rd       = id_rd;
      ex_d.rs1_data = id_rs1_data;
      ex_d.rs2_data = id_rs2_data;
      ex_d.imm      = id_imm;
      ex_d.RegWEn   = id_RegWEn;
      ex_d.MemRead  = id_MemRead;
      ex_d.MemWrite = id_MemWrite;
      ex_d.ctrl     = id_ctrl;
      state_d       = RUN;
    end
  end

  // ID/EX register and stall-state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      state_q <= RUN;
    end else begin
      ex_q    <= ex_d;
      state_q <= state_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_pc       = ex_q.pc;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_rd       = ex_q.rd;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign ex_imm      = ex_q.imm;
  assign ex_RegWEn   = ex_q.RegWEn;
  assign ex_MemRead  = ex_q.MemRead;
  assign ex_MemWrite = ex_q.MemWrite;
  assign ex_ctrl     = ex_q.ctrl;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] lu_cnt_q;
  logic [31:0] flush_cnt_q;

  // Stall and flush cycle counters; both outputs are low while frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (lu_stall)    lu_cnt_q    <= lu_cnt_q + 32'd1;
      if (if_id_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_lu_cnt    = lu_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
